exp_pipe_nlane: RTL and testbench

//   Multi-lane, integer-only exponential (i-exp) for the softmax datapath.
//   Per lane: z = floor(-q*qln2_inv >> FP_BITS), r = q + z*qln2, out = ((r+qb)*r + qc) >> z.

---
 rtl/exp_pipe_nlane.sv | 194 +++++++++++++++++++
 tb/tb_exp_pipe_nlane.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/exp_pipe_nlane.sv
// Multi-lane integer exponential for the softmax datapath.
// Six-stage valid/ready pipeline with run-time coefficients.
module exp_pipe_nlane #(
  parameter int D_W     = 32,
  parameter int FP_BITS = 30,
  parameter int N_LANE  = 4,
  parameter int Z_MAX   = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [D_W-1:0]          cfg_qb,
  input  logic [D_W-1:0]          cfg_qc,
  input  logic [D_W-1:0]          cfg_qln2,
  input  logic [D_W-1:0]          cfg_qln2_inv,
  output logic                    cfg_err,
  output logic                    busy,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [N_LANE*D_W-1:0]   s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [N_LANE*D_W-1:0]   m_data,
  output logic                    m_last
);
  localparam int IW = 2*D_W+2;
  localparam int ZW = $clog2(Z_MAX+1);
  localparam logic signed [IW-1:0] ZMAX_W = IW'(Z_MAX);
  localparam logic signed [IW-1:0] OMAX =
    {{(D_W+3){1'b0}}, {(D_W-1){1'b1}}};

  typedef logic signed [D_W-1:0] coef_t;
  typedef logic signed [IW-1:0]  wide_t;

  function automatic wide_t sx(input coef_t v);
    return {{(IW-D_W){v[D_W-1]}}, v};
  endfunction

  logic [5:0] v_q, v_d, last_q, last_d;
  logic       cfg_err_q, cfg_err_d, adv;
  coef_t qb_q, qb_d, qc_q, qc_d, qln2_q, qln2_d, qinv_q, qinv_d;

  // Coefficients ride with each beat so a reload never affects it.
  coef_t s0_qb_q, s0_qb_d, s0_qc_q, s0_qc_d;
  coef_t s0_qln2_q, s0_qln2_d, s0_qinv_q, s0_qinv_d;
  coef_t s1_qb_q, s1_qb_d, s1_qc_q, s1_qc_d, s1_qln2_q, s1_qln2_d;
  coef_t s2_qb_q, s2_qb_d, s2_qc_q, s2_qc_d, s2_qln2_q, s2_qln2_d;
  coef_t s3_qb_q, s3_qb_d, s3_qc_q, s3_qc_d;
  coef_t s4_qc_q, s4_qc_d;

  wide_t s0_q_q [N_LANE], s0_q_d [N_LANE];
  wide_t s0_n_q [N_LANE], s0_n_d [N_LANE];
  wide_t s1_p_q [N_LANE], s1_p_d [N_LANE];
  wide_t s1_q_q [N_LANE], s1_q_d [N_LANE];
  wide_t s2_q_q [N_LANE], s2_q_d [N_LANE];
  wide_t s3_r_q [N_LANE], s3_r_d [N_LANE];
  wide_t s4_t_q [N_LANE], s4_t_d [N_LANE];
  logic [ZW-1:0] s2_z_q [N_LANE], s2_z_d [N_LANE];
  logic [ZW-1:0] s3_z_q [N_LANE], s3_z_d [N_LANE];
  logic [ZW-1:0] s4_z_q [N_LANE], s4_z_d [N_LANE];
  logic [N_LANE-1:0] s2_zf_q, s2_zf_d, s3_zf_q, s3_zf_d;
  logic [N_LANE-1:0] s4_zf_q, s4_zf_d;
  logic [N_LANE*D_W-1:0] out_q, out_d;

  wide_t x_t, zr_t, y_t;
  logic  zf_t;

  assign busy    = |v_q;
  assign m_valid = v_q[5];
  assign m_last  = last_q[5];
  assign m_data  = out_q;
  assign cfg_err = cfg_err_q;
  assign adv     = !v_q[5] || m_ready;
  assign s_ready = adv;

  always_comb begin
    v_d = v_q;
    last_d = last_q;
    cfg_err_d = cfg_err_q | (cfg_we & busy);
    qb_d = qb_q;
    qc_d = qc_q;
    qln2_d = qln2_q;
    qinv_d = qinv_q;
    s0_qb_d = s0_qb_q;     s0_qc_d = s0_qc_q;
    s0_qln2_d = s0_qln2_q; s0_qinv_d = s0_qinv_q;
    s1_qb_d = s1_qb_q;     s1_qc_d = s1_qc_q;
    s1_qln2_d = s1_qln2_q;
    s2_qb_d = s2_qb_q;     s2_qc_d = s2_qc_q;
    s2_qln2_d = s2_qln2_q;
    s3_qb_d = s3_qb_q;     s3_qc_d = s3_qc_q;
    s4_qc_d = s4_qc_q;
    s0_q_d = s0_q_q;  s0_n_d = s0_n_q;
    s1_p_d = s1_p_q;  s1_q_d = s1_q_q;
    s2_q_d = s2_q_q;  s2_z_d = s2_z_q;
    s2_zf_d = s2_zf_q;
    s3_r_d = s3_r_q;  s3_z_d = s3_z_q;
    s3_zf_d = s3_zf_q;
    s4_t_d = s4_t_q;  s4_z_d = s4_z_q;
    s4_zf_d = s4_zf_q;
    out_d = out_q;
    x_t = '0;
    zr_t = '0;
    y_t = '0;
    zf_t = 1'b0;
    if (cfg_we && !busy) begin
      qb_d = cfg_qb;
      qc_d = cfg_qc;
      qln2_d = cfg_qln2;
      qinv_d = cfg_qln2_inv;
    end
    if (adv) begin
      v_d = {v_q[4:0], s_valid};
      last_d = {last_q[4:0], s_last};
      s0_qb_d = qb_q;        s0_qc_d = qc_q;
      s0_qln2_d = qln2_q;    s0_qinv_d = qinv_q;
      s1_qb_d = s0_qb_q;     s1_qc_d = s0_qc_q;
      s1_qln2_d = s0_qln2_q;
      s2_qb_d = s1_qb_q;     s2_qc_d = s1_qc_q;
      s2_qln2_d = s1_qln2_q;
      s3_qb_d = s2_qb_q;     s3_qc_d = s2_qc_q;
      s4_qc_d = s3_qc_q;
      for (int i = 0; i < N_LANE; i++) begin
        x_t = {{(IW-D_W){s_data[i*D_W+D_W-1]}},
               s_data[i*D_W +: D_W]};
        if (!x_t[IW-1]) x_t = '0;
        s0_q_d[i] = x_t;
        s0_n_d[i] = -x_t;
        s1_p_d[i] = s0_n_q[i] * sx(s0_qinv_q);
        s1_q_d[i] = s0_q_q[i];
        zr_t = s1_p_q[i] >>> FP_BITS;
        zf_t = zr_t > ZMAX_W;
        s2_zf_d[i] = zf_t;
        s2_z_d[i] = zf_t ? '0 : zr_t[ZW-1:0];
        s2_q_d[i] = s1_q_q[i];
        x_t = {{(IW-ZW){1'b0}}, s2_z_q[i]};
        s3_r_d[i] = s2_q_q[i] + x_t * sx(s2_qln2_q);
        s3_z_d[i] = s2_z_q[i];
        s3_zf_d[i] = s2_zf_q[i];
        s4_t_d[i] = (s3_r_q[i] + sx(s3_qb_q)) * s3_r_q[i];
        s4_z_d[i] = s3_z_q[i];
        s4_zf_d[i] = s3_zf_q[i];
        y_t = (s4_t_q[i] + sx(s4_qc_q)) >>> s4_z_q[i];
        if (s4_zf_q[i] || y_t[IW-1])
          out_d[i*D_W +: D_W] = '0;
        else if (y_t > OMAX)
          out_d[i*D_W +: D_W] = OMAX[D_W-1:0];
        else
          out_d[i*D_W +: D_W] = y_t[D_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      last_q <= '0;
      out_q <= '0;
      cfg_err_q <= 1'b0;
      qb_q <= '0;
      qc_q <= '0;
      qln2_q <= '0;
      qinv_q <= '0;
    end else begin
      v_q <= v_d;
      last_q <= last_d;
      out_q <= out_d;
      cfg_err_q <= cfg_err_d;
      qb_q <= qb_d;
      qc_q <= qc_d;
      qln2_q <= qln2_d;
      qinv_q <= qinv_d;
    end
  end

  always_ff @(posedge clk) begin
    s0_qb_q <= s0_qb_d;     s0_qc_q <= s0_qc_d;
    s0_qln2_q <= s0_qln2_d; s0_qinv_q <= s0_qinv_d;
    s1_qb_q <= s1_qb_d;     s1_qc_q <= s1_qc_d;
    s1_qln2_q <= s1_qln2_d;
    s2_qb_q <= s2_qb_d;     s2_qc_q <= s2_qc_d;
    s2_qln2_q <= s2_qln2_d;
    s3_qb_q <= s3_qb_d;     s3_qc_q <= s3_qc_d;
    s4_qc_q <= s4_qc_d;
    s0_q_q <= s0_q_d;  s0_n_q <= s0_n_d;
    s1_p_q <= s1_p_d;  s1_q_q <= s1_q_d;
    s2_q_q <= s2_q_d;  s2_z_q <= s2_z_d;
    s2_zf_q <= s2_zf_d;
    s3_r_q <= s3_r_d;  s3_z_q <= s3_z_d;
    s3_zf_q <= s3_zf_d;
    s4_t_q <= s4_t_d;  s4_z_q <= s4_z_d;
    s4_zf_q <= s4_zf_d;
  end
endmodule

// File: tb/tb_exp_pipe_nlane.sv
// Directed bench for exp_pipe_nlane: latency, clamps, saturation,
// backpressure, coefficient load rules and reset flush.
module tb_exp_pipe_nlane;
  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [31:0]  cfg_qb, cfg_qc, cfg_qln2, cfg_qln2_inv;
  logic         cfg_err, busy;
  logic         s_valid, s_ready, s_last;
  logic [127:0] s_data;
  logic         m_valid, m_ready, m_last;
  logic [127:0] m_data;

  int n_chk = 0;
  int n_pass = 0;
  logic [128:0] exp_q[$];

  localparam logic [31:0] QINV = 32'd10737419;

  exp_pipe_nlane dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we),
    .cfg_qb(cfg_qb), .cfg_qc(cfg_qc), .cfg_qln2(cfg_qln2),
    .cfg_qln2_inv(cfg_qln2_inv), .cfg_err(cfg_err), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  function automatic logic [127:0] pk(input int a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] ref_exp(input longint q, qb, qc,
                                          input longint qln2, qinv);
    longint z, r, t, y;
    if (q > 0) q = 0;
    z = ((-q) * qinv) >>> 30;
    if (z > 31) return 32'd0;
    r = q + z * qln2;
    t = (r + qb) * r;
    y = (t + qc) >>> z;
    if (y < 0) return 32'd0;
    if (y > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
    return y[31:0];
  endfunction

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("extra_beat", 1, 0);
      else begin
        logic [128:0] e;
        e = exp_q.pop_front();
        chk("m_data", m_data, e[127:0]);
        chk("m_last", {127'd0, m_last}, {127'd0, e[128]});
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic l,
                      input logic [127:0] want);
    int k;
    exp_q.push_back({l, want});
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!s_ready && k < 100) begin
      k++;
      @(negedge clk);
    end
    if (k == 100) chk("s_ready_timeout", 0, 1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 300) begin
      k++;
      @(negedge clk);
    end
    if (k == 300) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_set(input logic [31:0] b, c, l, inv);
    cfg_qb = b;
    cfg_qc = c;
    cfg_qln2 = l;
    cfg_qln2_inv = inv;
    cfg_we = 1'b1;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  initial begin
    int cnt;
    int q[4];
    logic [127:0] d, e;
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_qb = '0; cfg_qc = '0; cfg_qln2 = '0; cfg_qln2_inv = '0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", {127'd0, m_valid}, 0);
    chk("rst_busy", {127'd0, busy}, 0);
    chk("rst_cfg_err", {127'd0, cfg_err}, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", {127'd0, m_last}, 0);
    chk("rst_s_ready", {127'd0, s_ready}, 1);
    @(posedge clk);
    #1;

    cfg_set(32'd300, 32'd20000, 32'd100, QINV);
    send(pk(0, -50, -100, -150), 1'b1, pk(20000, 7500, 10000, 3750));
    cnt = 0;
    while (!m_valid && cnt < 20) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("latency", cnt + 1, 6);
    send(pk(7, -100000, 0, 0), 1'b0, pk(20000, 0, 20000, 20000));
    wait_idle();

    cfg_set(32'h80000000, 32'd20000, 32'd100, QINV);
    send(pk(-50, -50, -50, -50), 1'b1,
         pk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF));
    wait_idle();
    cfg_set(32'd300, -32'sd30000, 32'd100, QINV);
    send(pk(-50, -50, -50, -50), 1'b0, pk(0, 0, 0, 0));
    wait_idle();

    cfg_set(32'd300, 32'd20000, 32'd100, QINV);
    fork
      begin
        for (int b = 0; b < 50; b++) begin
          for (int j = 0; j < 4; j++) q[j] = -int'($urandom_range(3000));
          d = pk(q[0], q[1], q[2], q[3]);
          for (int j = 0; j < 4; j++)
            e[j*32 +: 32] = ref_exp(q[j], 300, 20000, 100, 10737419);
          send(d, 1'($urandom_range(1)), e);
        end
      end
      begin
        repeat (15) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          chk("stall_s_ready", {127'd0, s_ready}, {127'd0, !m_valid});
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    wait_idle();
    chk("sb_empty", exp_q.size(), 0);

    send(pk(-50, -50, -50, -50), 1'b0, pk(7500, 7500, 7500, 7500));
    cfg_set(32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("cfg_err_set", {127'd0, cfg_err}, 1);
    wait_idle();
    send(pk(-50, 0, -100, -150), 1'b1, pk(7500, 20000, 10000, 3750));
    wait_idle();
    chk("cfg_err_sticky", {127'd0, cfg_err}, 1);

    cfg_qb = 32'd300; cfg_qc = 32'd10000;
    cfg_qln2 = 32'd100; cfg_qln2_inv = QINV;
    cfg_we = 1'b1;
    send(pk(0, 0, 0, 0), 1'b0, pk(20000, 20000, 20000, 20000));
    cfg_we = 1'b0;
    send(pk(0, 0, 0, 0), 1'b1, pk(10000, 10000, 10000, 10000));
    wait_idle();
    chk("sb_empty2", exp_q.size(), 0);

    send(pk(-50, -50, -50, -50), 1'b0, 0);
    send(pk(-50, -50, -50, -50), 1'b0, 0);
    send(pk(-50, -50, -50, -50), 1'b1, 0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("flush_m_valid", {127'd0, m_valid}, 0);
    chk("flush_busy", {127'd0, busy}, 0);
    chk("flush_cfg_err", {127'd0, cfg_err}, 0);
    repeat (10) begin
      @(negedge clk);
      chk("no_stale", {127'd0, m_valid}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
